// File: rtl/pc_table_pkg.sv
// Shared types and default constants for the PC target table.
package pc_table_pkg;

    // Entry addressing mode: absolute target or PC-relative offset.
    typedef enum logic {
        ABS = 1'b0,
        REL = 1'b1
    } mode_e;

    // Per-entry control bits. The D-bit value field sits in a parallel array
    // because its width is a per-instance parameter.
    typedef struct packed {
        logic  valid;
        mode_e mode;
    } entry_t;

    localparam int unsigned INIT0_DEFAULT = 4;
    localparam int unsigned INIT1_DEFAULT = 8;

endpackage

// File: rtl/pc_rel_add.sv
// D-bit PC plus offset adder. A two's-complement offset wraps naturally mod 2^D.
module pc_rel_add #(
    parameter int unsigned D = 8
) (
    input  logic [D-1:0] pc,
    input  logic [D-1:0] offset,
    output logic [D-1:0] sum
);

    assign sum = pc + offset;

endmodule

// File: rtl/pc_target_table.sv
// Small flop-based branch target table with a registered, write-first lookup port.
module pc_target_table
    import pc_table_pkg::*;
#(
    parameter int unsigned D     = 8,
    parameter int unsigned N     = 8,
    parameter int unsigned IW    = $clog2(N),
    parameter int unsigned INIT0 = INIT0_DEFAULT,
    parameter int unsigned INIT1 = INIT1_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [D-1:0]  wr_target,
    input  logic          wr_rel,
    input  logic          clr,
    input  logic          branch,
    input  logic [IW-1:0] idx,
    input  logic [D-1:0]  pc,
    output logic [D-1:0]  target,
    output logic          taken,
    output logic          miss,
    output logic [7:0]    miss_cnt
);

    entry_t         flags_q [N];
    logic [D-1:0]   value_q [N];

    entry_t         rd_flags;
    logic [D-1:0]   rd_value;
    logic [D-1:0]   rel_sum;

    logic [D-1:0]   target_d, target_q;
    logic           taken_d, taken_q;
    logic           miss_d, miss_q;
    logic [7:0]     miss_cnt_d, miss_cnt_q;

    // Entry storage: reset image, clear-all, then a write that overrides the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                if (i == 0) begin
                    flags_q[i] <= '{valid: 1'b1, mode: ABS};
                    value_q[i] <= D'(INIT0);
                end else if (i == 1) begin
                    flags_q[i] <= '{valid: 1'b1, mode: ABS};
                    value_q[i] <= D'(INIT1);
                end else begin
                    flags_q[i] <= '{valid: 1'b0, mode: ABS};
                    value_q[i] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr_en && (wr_idx == IW'(i))) begin
                    flags_q[i] <= '{valid: 1'b1, mode: mode_e'(wr_rel)};
                    value_q[i] <= wr_target;
                end else if (clr) begin
                    flags_q[i].valid <= 1'b0;
                end
            end
        end
    end

    // Read port: stored (pre-clear) contents, bypassed by a same-index write.
    always_comb begin
        rd_flags = flags_q[idx];
        rd_value = value_q[idx];
        if (wr_en && (wr_idx == idx)) begin
            rd_flags = '{valid: 1'b1, mode: mode_e'(wr_rel)};
            rd_value = wr_target;
        end
    end

    pc_rel_add #(
        .D(D)
    ) u_rel_add (
        .pc    (pc),
        .offset(rd_value),
        .sum   (rel_sum)
    );

    // Lookup result and saturating miss count for the next cycle.
    always_comb begin
        target_d = '0;
        taken_d  = 1'b0;
        miss_d   = 1'b0;
        if (branch) begin
            if (rd_flags.valid) begin
                taken_d  = 1'b1;
                target_d = (rd_flags.mode == REL) ? rel_sum : rd_value;
            end else begin
                miss_d = 1'b1;
            end
        end
        miss_cnt_d = miss_cnt_q;
        if (miss_d && (miss_cnt_q != 8'hFF)) begin
            miss_cnt_d = miss_cnt_q + 8'd1;
        end
    end

    // Output registers; reset discards any lookup in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_q   <= '0;
            taken_q    <= 1'b0;
            miss_q     <= 1'b0;
            miss_cnt_q <= 8'd0;
        end else begin
            target_q   <= target_d;
            taken_q    <= taken_d;
            miss_q     <= miss_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign target   = target_q;
    assign taken    = taken_q;
    assign miss     = miss_q;
    assign miss_cnt = miss_cnt_q;

endmodule
